matvec_result_packer: RTL and testbench

- Downstream stage of the 8x8 matrix-vector multiplier; consumes its 28-bit signed result stream over valid/ready.
- Buffers results in a small FIFO and tags each word with its row index and an end-of-vector marker.
- Tracks completed vectors and saturated results, so the consumer side (host/DMA) can frame vectors and detect overflow.

---
 rtl/matvec_pkg.sv | 32 +++
 rtl/matvec_sync_fifo.sv | 71 +++++++
 rtl/matvec_result_packer.sv | 147 ++++++++++++++
 tb/tb_matvec_result_packer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared types and constants for the 8x8 matrix-vector multiplier datapath.
// The multiplier stage and the result packer both import this package so that
// the result width and the saturation codes stay in one place.
package matvec_pkg;

  // Width of one multiplier result word.
  localparam int DATA_W = 28;

  // Default matrix dimension: results per vector.
  localparam int ROWS = 8;
  localparam int IDX_W = $clog2(ROWS);

  // Codes the multiplier emits when an accumulation clips.
  localparam logic [DATA_W-1:0] SAT_POS = 28'h7FFFFFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 28'h8000000;

  // One signed result word.
  typedef logic signed [DATA_W-1:0] result_t;

  // A result tagged with its row position inside the vector.
  typedef struct packed {
    result_t          data;
    logic [IDX_W-1:0] index;
    logic             last;
  } tagged_result_t;

  // True when a result carries one of the two clip codes.
  function automatic logic is_saturated(input result_t value);
    return (value == SAT_POS) || (value == SAT_NEG);
  endfunction

endpackage

// File: rtl/matvec_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is read
// combinationally from the storage array, so rd_data is valid whenever
// empty is low and does not move until a pop.
module matvec_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Writes into a full FIFO and reads from an empty one are ignored so the
  // occupancy count can never run out of range.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array: no reset, contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/matvec_result_packer.sv
// Result packer behind the matrix-vector multiplier. Each accepted result is
// tagged with its row index and an end-of-vector bit, buffered in a FIFO, and
// presented to the host/DMA side as a first-word-fall-through stream. Two
// statistics are kept for the consumer: completed vectors and a sticky
// saturation flag.
module matvec_result_packer
  import matvec_pkg::*;
#(
  parameter int          S              = 8,
  parameter int          DEPTH          = 16,
  parameter int          DATA_W         = 28,
  parameter logic [15:0] VEC_COUNT_INIT = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [$clog2(S)-1:0] out_index,
  output logic                 out_last,
  input  logic                 clear_stats,
  output logic [15:0]          vec_count,
  output logic                 sat_flag
);

  localparam int IW = $clog2(S);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IW-1:0]     index;
    logic              last;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic          ready_en;
  logic [IW-1:0] row_idx;
  logic          row_is_last;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  entry_t        wr_entry;
  entry_t        head;
  logic [EW-1:0] head_bits;
  logic [15:0]   vec_count_q;
  logic          sat_flag_q;

  // Input side: there is no bypass, so a full FIFO refuses a word even when
  // the consumer pops in the same cycle. ready_en keeps in_ready low during
  // reset and for the edge on which reset is released.
  assign in_ready    = ready_en && !fifo_full;
  assign out_valid   = !fifo_empty;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign row_is_last = (row_idx == IW'(S - 1));

  // Build the tagged entry for the word currently offered upstream.
  always_comb begin
    wr_entry       = '0;
    wr_entry.data  = in_data;
    wr_entry.index = row_idx;
    wr_entry.last  = row_is_last;
  end

  matvec_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head = entry_t'(head_bits);

  // Head fields are forced to zero while nothing valid is buffered, which
  // also covers the reset state since the storage array itself is not reset.
  always_comb begin
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data  = head.data;
      out_index = head.index;
      out_last  = head.last;
    end
  end

  // in_ready comes up on the first clock edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Row position of the next accepted word; wraps at the end of each vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_idx <= '0;
    end else if (push) begin
      if (row_is_last) begin
        row_idx <= '0;
      end else begin
        row_idx <= row_idx + IW'(1);
      end
    end
  end

  // Completed-vector counter: counts pops of a vector's last word, sticks at
  // all-ones, and a same-cycle clear beats the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec_count_q <= VEC_COUNT_INIT;
    end else if (clear_stats) begin
      vec_count_q <= '0;
    end else if (pop && head.last && (vec_count_q != 16'hFFFF)) begin
      vec_count_q <= vec_count_q + 16'd1;
    end
  end

  // Sticky saturation flag: set when a clip code is accepted, cleared only by
  // clear_stats, which also wins over a same-cycle set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag_q <= 1'b0;
    end else if (clear_stats) begin
      sat_flag_q <= 1'b0;
    end else if (push && is_saturated(in_data)) begin
      sat_flag_q <= 1'b1;
    end
  end

  assign vec_count = vec_count_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_matvec_result_packer.sv
// Self-checking bench for matvec_result_packer. A queue-based model tracks
// what the packer should hold and is compared against every output on every
// cycle; a table of hand-derived vectors and a few directed sequences cover
// framing, saturation, backpressure and same-cycle corner cases.
module tb_matvec_result_packer;

  localparam int S     = 8;
  localparam int DEPTH = 16;
  localparam int DW    = 28;
  localparam int IW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          clear_stats = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic [15:0]   vec_count;
  logic          sat_flag;

  logic          h_in_valid = 1'b0;
  logic          h_out_ready = 1'b0;
  logic [DW-1:0] h_in_data = 28'd7;
  logic          h_in_ready;
  logic          h_out_valid;
  logic [DW-1:0] h_out_data;
  logic [IW-1:0] h_out_index;
  logic          h_out_last;
  logic [15:0]   h_vec_count;
  logic          h_sat_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matvec_result_packer #(.S(S), .DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .clear_stats(clear_stats), .vec_count(vec_count), .sat_flag(sat_flag)
  );

  matvec_result_packer #(.S(S), .DEPTH(DEPTH), .DATA_W(DW), .VEC_COUNT_INIT(16'hFFFE)) dut_hi (
    .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_data(h_in_data), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_data(h_out_data), .out_index(h_out_index), .out_last(h_out_last),
    .clear_stats(1'b0), .vec_count(h_vec_count), .sat_flag(h_sat_flag)
  );

  // Reference model: the buffered words in arrival order plus statistics.
  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } word_t;

  word_t mq[$];
  int    m_row = 0;
  int    m_vec = 0;
  bit    m_sat = 1'b0;
  bit    m_started = 1'b0;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          clr;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [IW-1:0] e_idx;
    logic          e_last;
    logic [15:0]   e_vec;
    logic          e_sat;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(logic iv, logic [DW-1:0] d, logic ordy, logic clr,
                              logic ev, logic [DW-1:0] ed, logic [IW-1:0] ei,
                              logic el, logic [15:0] evc, logic es);
    row_t r;
    r.iv = iv; r.d = d; r.ordy = ordy; r.clr = clr;
    r.e_valid = ev; r.e_data = ed; r.e_idx = ei; r.e_last = el;
    r.e_vec = evc; r.e_sat = es;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_row = 0;
    m_vec = 0;
    m_sat = 1'b0;
    m_started = 1'b0;
  endtask

  // Compare every output against what the model says the packer holds.
  task automatic check_model(input string tag);
    logic  e_ready;
    logic  e_valid;
    word_t h;
    e_ready = m_started && (mq.size() < DEPTH);
    e_valid = (mq.size() != 0);
    h = '0;
    if (e_valid) h = mq[0];
    check_output({tag, " in_ready"},  32'(in_ready),  32'(e_ready));
    check_output({tag, " out_valid"}, 32'(out_valid), 32'(e_valid));
    check_output({tag, " out_data"},  32'(out_data),  32'(h.data));
    check_output({tag, " out_index"}, 32'(out_index), 32'(h.idx));
    check_output({tag, " out_last"},  32'(out_last),  32'(h.last));
    check_output({tag, " vec_count"}, 32'(vec_count), 32'(m_vec));
    check_output({tag, " sat_flag"},  32'(sat_flag),  32'(m_sat));
  endtask

  // One cycle: drive inputs at the falling edge, check, advance the model to
  // what the next rising edge should produce, then wait for the next falling edge.
  task automatic apply_stimulus(input logic iv, input logic [DW-1:0] d, input logic ordy,
                                input logic clr, input string tag);
    logic  e_ready;
    logic  e_valid;
    word_t w;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    clear_stats = clr;
    check_model(tag);
    if (!reset) begin
      model_clear();
    end else begin
      e_ready = m_started && (mq.size() < DEPTH);
      e_valid = (mq.size() != 0);
      if (ordy && e_valid) begin
        w = mq.pop_front();
        if (w.last && m_vec < 65535) m_vec++;
      end
      if (iv && e_ready) begin
        w.data = d;
        w.idx = m_row[IW-1:0];
        w.last = (m_row == S - 1);
        mq.push_back(w);
        if (d == 28'h7FFFFFF || d == 28'h8000000) m_sat = 1'b1;
        m_row = (m_row + 1) % S;
      end
      if (clr) begin
        m_vec = 0;
        m_sat = 1'b0;
      end
      m_started = 1'b1;
    end
    @(negedge clk);
  endtask

  // Assert reset right away (asynchronously), check outputs drop, hold, release.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_clear();
    check_output({tag, " async out_valid"}, 32'(out_valid), 32'd0);
    check_output({tag, " async in_ready"},  32'(in_ready),  32'd0);
    check_output({tag, " async out_data"},  32'(out_data),  32'd0);
    check_output({tag, " async out_index"}, 32'(out_index), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b0, {tag, " hold"});
    reset = 1'b1;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, {tag, " release"});
    check_output({tag, " in_ready after release"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] r;
    int accepts;

    // Single vector 1..8, then the saturation/clear sequence.
    tbl.push_back(mk(1, 28'd1, 1, 0, 0, 28'd0, 3'd0, 0, 16'd0, 0));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(mk(1, 28'(k + 1), 1, 0, 1, 28'(k), 3'(k - 1), 0, 16'd0, 0));
    tbl.push_back(mk(0, 28'd0, 1, 0, 1, 28'd8, 3'd7, 1, 16'd0, 0));
    tbl.push_back(mk(1, 28'h7FFFFFF, 0, 0, 0, 28'd0, 3'd0, 0, 16'd1, 0));
    tbl.push_back(mk(1, 28'd5, 0, 0, 1, 28'h7FFFFFF, 3'd0, 0, 16'd1, 1));
    tbl.push_back(mk(1, 28'd5, 0, 0, 1, 28'h7FFFFFF, 3'd0, 0, 16'd1, 1));
    tbl.push_back(mk(0, 28'd0, 0, 1, 1, 28'h7FFFFFF, 3'd0, 0, 16'd1, 1));
    tbl.push_back(mk(1, 28'h8000000, 1, 0, 1, 28'h7FFFFFF, 3'd0, 0, 16'd0, 0));
    tbl.push_back(mk(0, 28'd0, 1, 0, 1, 28'd5, 3'd1, 0, 16'd0, 1));
    tbl.push_back(mk(0, 28'd0, 1, 0, 1, 28'd5, 3'd2, 0, 16'd0, 1));
    tbl.push_back(mk(0, 28'd0, 1, 0, 1, 28'h8000000, 3'd3, 0, 16'd0, 1));
    tbl.push_back(mk(0, 28'd0, 0, 0, 0, 28'd0, 3'd0, 0, 16'd0, 1));

    // Reset held low for three cycles, then released.
    @(negedge clk);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b0, "reset hold");
    reset = 1'b1;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, "reset release");
    check_output("in_ready one cycle after release", 32'(in_ready), 32'd1);

    // Table-driven vectors.
    foreach (tbl[i]) begin
      check_output($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      check_output($sformatf("tbl%0d out_data", i),  32'(out_data),  32'(tbl[i].e_data));
      check_output($sformatf("tbl%0d out_index", i), 32'(out_index), 32'(tbl[i].e_idx));
      check_output($sformatf("tbl%0d out_last", i),  32'(out_last),  32'(tbl[i].e_last));
      check_output($sformatf("tbl%0d vec_count", i), 32'(vec_count), 32'(tbl[i].e_vec));
      check_output($sformatf("tbl%0d sat_flag", i),  32'(sat_flag),  32'(tbl[i].e_sat));
      apply_stimulus(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].clr, $sformatf("tbl%0d", i));
    end

    // Reset in the middle of a partially buffered vector.
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 28'(40 + i), 1'b0, 1'b0, "pre-reset push");
    #2;
    do_reset("midreset");
    apply_stimulus(1'b1, 28'h123, 1'b0, 1'b0, "post-reset push");
    check_output("post-reset out_index", 32'(out_index), 32'd0);
    check_output("post-reset out_data", 32'(out_data), 32'h123);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, "post-reset pop");

    // Fill against a stalled consumer.
    accepts = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) accepts++;
      r = 28'($urandom);
      apply_stimulus(1'b1, r, 1'b0, 1'b0, "fill");
    end
    check_output("accepts until full", 32'(accepts), 32'd16);
    r = 28'($urandom);
    apply_stimulus(1'b1, r, 1'b1, 1'b0, "first pop while full");
    check_output("in_ready after first pop", 32'(in_ready), 32'd1);
    for (int i = 0; i < 40; i++) begin
      r = 28'($urandom);
      apply_stimulus(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)), 1'b0, "stall");
    end
    for (int i = 0; i < 20; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0, "drain");
    check_output("drained out_valid", 32'(out_valid), 32'd0);

    // Push and pop together at occupancy 4, then measure remaining room.
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 28'(200 + i), 1'b0, 1'b0, "occ fill");
    apply_stimulus(1'b1, 28'd204, 1'b1, 1'b0, "occ push+pop");
    accepts = 0;
    for (int i = 0; i < 16; i++) begin
      if (in_ready) accepts++;
      apply_stimulus(1'b1, 28'(300 + i), 1'b0, 1'b0, "occ room");
    end
    check_output("room after push+pop at occupancy 4", 32'(accepts), 32'd12);
    for (int i = 0; i < 20; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0, "drain");

    // Random traffic, first congested then mostly flowing.
    for (int i = 0; i < 300; i++) begin
      r = 28'($urandom);
      case ($urandom_range(0, 15))
        0: r = 28'h7FFFFFF;
        1: r = 28'h8000000;
        default: ;
      endcase
      apply_stimulus(1'($urandom_range(0, 3) != 0), r,
                     (i < 150) ? 1'($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 31) == 0), "rand");
    end
    for (int i = 0; i < 20; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0, "drain");

    // Clear in the same cycle the fourth vector's last word pops.
    do_reset("vec3");
    for (int i = 0; i < 24; i++) apply_stimulus(1'b1, 28'(100 + i), 1'b1, 1'b0, "three vectors");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0, "three vectors drain");
    check_output("vec_count after three vectors", 32'(vec_count), 32'd3);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 28'(500 + i), 1'b0, 1'b0, "fourth vector");
    for (int i = 0; i < 7; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0, "fourth vector pop");
    check_output("last word at head", 32'(out_last), 32'd1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1, "clear with last pop");
    check_output("vec_count after clear+pop", 32'(vec_count), 32'd0);

    // Counter ceiling on the instance preloaded just below all-ones.
    check_output("hi preload", 32'(h_vec_count), 32'hFFFE);
    h_in_valid = 1'b1;
    h_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check_output("hi before first vector", 32'(h_vec_count), 32'hFFFE);
    for (int i = 0; i < 8; i++) @(negedge clk);
    check_output("hi after first vector", 32'(h_vec_count), 32'hFFFF);
    for (int i = 0; i < 40; i++) @(negedge clk);
    check_output("hi stays at ceiling", 32'(h_vec_count), 32'hFFFF);
    h_in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
